// File: rtl/fios_mm_sequencer.sv
// fios_mm_sequencer: control sequencer for the expanded FIOS Montgomery multiplier.
// Optional cycle counter output perf_cycles_o under FIOS_SEQ_PERF_CNT_EN.
module fios_mm_sequencer #(
  parameter int s        = 8,
  parameter int PE_NB    = 8,
  parameter int PE_DELAY = 6,
  parameter int M_LAT    = 3,
  parameter int RES_LAT  = 8,
  parameter int CNT_W    = 16
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [PE_NB-1:0]     a_reg_en_o,
  output logic                 feed_valid_o,
  output logic [$clog2(s+1)-1:0] feed_idx_o,
  output logic [2*PE_NB-1:0]   pe_phase_o,
  output logic [PE_NB-1:0]     m_reg_en_o,
  output logic                 res_valid_o,
  output logic [$clog2(s)-1:0] res_idx_o
`ifdef FIOS_SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     perf_cycles_o
`endif
);
  localparam int FW = $clog2(s+1);
  localparam int RW = $clog2(s);
  localparam logic [CNT_W-1:0] S_C    = CNT_W'(s);
  localparam logic [CNT_W-1:0] R0     = CNT_W'((PE_NB-1)*PE_DELAY + RES_LAT + 1);
  localparam logic [CNT_W-1:0] T_STOP = CNT_W'((PE_NB-1)*PE_DELAY + RES_LAT + s + 1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} st_t;
  st_t st, ns;
  logic [CNT_W-1:0] t, nt;
  logic run, fv, rv;
  logic [2*PE_NB-1:0] ph;
  logic [PE_NB-1:0] me;
  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_comb begin
    ns  = st == IDLE ? ((start_i && !abort_i) ? LOAD : IDLE) :
          (st == DONE || abort_i) ? IDLE :
          st == LOAD ? RUN :
          t == T_STOP ? DONE : RUN;
    nt  = (ns == RUN && st == RUN) ? t + 1'b1 : '0;
    run = ns == RUN;
    fv  = run && nt <= S_C;
    rv  = run && nt >= R0 && nt < R0 + S_C;
  end
  for (genvar i = 0; i < PE_NB; i++) begin : g_pe
    localparam logic [CNT_W-1:0] B = CNT_W'(i*PE_DELAY);
    assign ph[2*i+:2] = (!run || nt < B || nt > B + S_C) ? 2'b00 :
                        nt == B ? 2'b01 : nt == B + S_C ? 2'b11 : 2'b10;
    assign me[i] = run && nt == B + CNT_W'(M_LAT);
  end
`ifdef FIOS_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] pc;
`endif
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      st           <= IDLE;
      t            <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      a_reg_en_o   <= '0;
      feed_valid_o <= 1'b0;
      feed_idx_o   <= '0;
      pe_phase_o   <= '0;
      m_reg_en_o   <= '0;
      res_valid_o  <= 1'b0;
      res_idx_o    <= '0;
`ifdef FIOS_SEQ_PERF_CNT_EN
      pc            <= '0;
      perf_cycles_o <= '0;
`endif
    end else begin
      st           <= ns;
      t            <= nt;
      busy_o       <= ns != IDLE;
      done_o       <= ns == DONE;
      a_reg_en_o   <= {PE_NB{ns == LOAD}};
      feed_valid_o <= fv;
      feed_idx_o   <= fv ? FW'(nt) : '0;
      pe_phase_o   <= ph;
      m_reg_en_o   <= me;
      res_valid_o  <= rv;
      res_idx_o    <= rv ? RW'(nt - R0) : '0;
`ifdef FIOS_SEQ_PERF_CNT_EN
      pc <= ns == IDLE ? '0 : pc + 1'b1;
      if (ns == DONE) perf_cycles_o <= pc + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_fios_mm_sequencer.sv
// tb_fios_mm_sequencer: directed self-checking bench for fios_mm_sequencer.
module tb_fios_mm_sequencer;
  logic clock_i = 1'b0, reset_n_i, start_i, abort_i;
  logic busy_o, done_o, feed_valid_o, res_valid_o;
  logic [7:0] a_reg_en_o, m_reg_en_o;
  logic [3:0] feed_idx_o;
  logic [15:0] pe_phase_o;
  logic [2:0] res_idx_o;
`ifdef FIOS_SEQ_PERF_CNT_EN
  logic [15:0] perf_cycles_o;
`endif
  logic [42:0] outs;
  int n_run = 0, n_fail = 0, nd, dk;
  assign outs = {busy_o, done_o, a_reg_en_o, feed_valid_o, feed_idx_o, pe_phase_o,
                 m_reg_en_o, res_valid_o, res_idx_o};
  always #5 clock_i = ~clock_i;
  fios_mm_sequencer dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .a_reg_en_o(a_reg_en_o),
    .feed_valid_o(feed_valid_o), .feed_idx_o(feed_idx_o), .pe_phase_o(pe_phase_o),
    .m_reg_en_o(m_reg_en_o), .res_valid_o(res_valid_o), .res_idx_o(res_idx_o)
`ifdef FIOS_SEQ_PERF_CNT_EN
    , .perf_cycles_o(perf_cycles_o)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask
  task automatic go();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask
  function automatic logic [1:0] ph(input int t, input int b);
    return (t == b) ? 2'd1 : (t > b && t < b + 8) ? 2'd2 : (t == b + 8) ? 2'd3 : 2'd0;
  endfunction
  initial begin
    reset_n_i = 1'b0;
    start_i   = 1'b0;
    abort_i   = 1'b0;
    step();
    step();
    check("reset_outs", outs, 0);
`ifdef FIOS_SEQ_PERF_CNT_EN
    check("reset_perf", perf_cycles_o, 0);
`endif
    reset_n_i = 1'b1;
    step();
    check("idle_outs", outs, 0);
    go();
    for (int k = 1; k <= 64; k++) begin
      check($sformatf("busy@%0d", k), busy_o, k <= 62);
      check($sformatf("done@%0d", k), done_o, k == 62);
      check($sformatf("areg@%0d", k), a_reg_en_o, k == 1 ? 8'hFF : 8'h00);
      check($sformatf("feed@%0d", k), {feed_valid_o, feed_idx_o},
            (k >= 2 && k <= 10) ? {1'b1, 4'(k-2)} : 5'd0);
      check($sformatf("res@%0d", k), {res_valid_o, res_idx_o},
            (k >= 53 && k <= 60) ? {1'b1, 3'(k-53)} : 4'd0);
      check($sformatf("ph0@%0d", k), pe_phase_o[1:0], ph(k-2, 0));
      check($sformatf("ph3@%0d", k), pe_phase_o[7:6], ph(k-2, 18));
      check($sformatf("ph7@%0d", k), pe_phase_o[15:14], ph(k-2, 42));
      check($sformatf("m0@%0d", k), m_reg_en_o[0], k-2 == 3);
      check($sformatf("m3@%0d", k), m_reg_en_o[3], k-2 == 21);
      check($sformatf("m7@%0d", k), m_reg_en_o[7], k-2 == 45);
      step();
    end
`ifdef FIOS_SEQ_PERF_CNT_EN
    check("perf_nominal", perf_cycles_o, 62);
`endif
    go();
    for (int k = 1; k < 22; k++) step();
    check("abort_busy_before", busy_o, 1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("abort_outs", outs, 0);
    nd = 0;
    for (int k = 0; k < 70; k++) begin
      if (done_o) nd++;
      step();
    end
    check("abort_no_done", nd, 0);
`ifdef FIOS_SEQ_PERF_CNT_EN
    check("perf_after_abort", perf_cycles_o, 62);
`endif
    go();
    nd = 0;
    dk = 0;
    for (int k = 1; k <= 66; k++) begin
      if (done_o) begin nd++; dk = k; end
      step();
    end
    check("rerun_done_cnt", nd, 1);
    check("rerun_done_cyc", dk, 62);
    go();
    nd = 0;
    dk = 0;
    for (int k = 1; k <= 70; k++) begin
      if (done_o) begin nd++; dk = k; end
      if (k == 20) check("busy_start_feed", feed_valid_o, 0);
      if (k == 53) check("busy_start_res", {res_valid_o, res_idx_o}, 4'b1000);
      start_i = (k == 7 || k == 32);
      step();
    end
    start_i = 1'b0;
    check("busy_start_done_cnt", nd, 1);
    check("busy_start_done_cyc", dk, 62);
    go();
    for (int k = 1; k < 42; k++) step();
    check("rst_busy_before", busy_o, 1);
    reset_n_i = 1'b0;
    step();
    reset_n_i = 1'b1;
    check("rst_mid_outs", outs, 0);
`ifdef FIOS_SEQ_PERF_CNT_EN
    check("perf_after_rst", perf_cycles_o, 0);
`endif
    start_i = 1'b1;
    abort_i = 1'b1;
    step();
    start_i = 1'b0;
    abort_i = 1'b0;
    check("start_abort_outs", outs, 0);
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      if (busy_o || done_o) nd++;
      step();
    end
    check("start_abort_stay_idle", nd, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
